// File: rtl/dmem_arbiter_if.sv
// Requester-side bus for the shared data memory arbiter.
// Ports: req/we/addr/wdata from requester; gnt/ack/rdata/err back from arbiter.
interface dmem_arbiter_if #(
    parameter int DW = 32
);
    logic          req;
    logic          we;
    logic [31:0]   addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          ack;
    logic [DW-1:0] rdata;
    logic          err;

    modport master (
        output req, we, addr, wdata,
        input  gnt, ack, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, ack, rdata, err
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer for the single-port data memory.
// Ports: clk, rst (async, active high); c = core port, d = debug port
// (dmem_arbiter_if.slave); m_en/m_we/m_addr/m_wdata to memory, m_rdata back.
module dmem_arbiter #(
    parameter int DW    = 32,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave c,
    dmem_arbiter_if.slave d,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    state_t        state;
    logic          last_d;
    logic          own_d;
    logic          rd_ok;
    logic          err_q;
    logic          c_ack_q;
    logic          d_ack_q;

    logic          c_win;
    logic          d_win;
    logic          idle_ok;
    logic          sel_we;
    logic          sel_oor;
    logic [31:0]   sel_addr;
    logic [DW-1:0] sel_wdata;

    // On a tie, C wins unless C was the last port served.
    always_comb begin
        idle_ok   = (state == IDLE) & ~rst;
        c_win     = c.req & (~d.req | last_d);
        d_win     = d.req & ~c_win;
        sel_we    = d_win ? d.we    : c.we;
        sel_addr  = d_win ? d.addr  : c.addr;
        sel_wdata = d_win ? d.wdata : c.wdata;
        // A single full-width compare covers both high bits and
        // low bits beyond DEPTH.
        sel_oor   = ~(sel_addr < DEPTH_W);
    end

    assign c.gnt   = idle_ok & c_win;
    assign d.gnt   = idle_ok & d_win;
    assign c.ack   = c_ack_q;
    assign d.ack   = d_ack_q;
    assign c.err   = c_ack_q & err_q;
    assign d.err   = d_ack_q & err_q;
    // Memory read data arrives in RESP; pass it only to the owner.
    assign c.rdata = (c_ack_q & rd_ok) ? m_rdata : '0;
    assign d.rdata = (d_ack_q & rd_ok) ? m_rdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            last_d  <= 1'b1;
            own_d   <= 1'b0;
            rd_ok   <= 1'b0;
            err_q   <= 1'b0;
            c_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
            m_en    <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (c_win | d_win) begin
                        state   <= ISSUE;
                        last_d  <= d_win;
                        own_d   <= d_win;
                        rd_ok   <= ~sel_we & ~sel_oor;
                        err_q   <= sel_oor;
                        m_en    <= ~sel_oor;
                        m_we    <= sel_we & ~sel_oor;
                        m_addr  <= sel_oor ? '0 : sel_addr[AW-1:0];
                        m_wdata <= sel_oor ? '0 : sel_wdata;
                    end
                end
                ISSUE: begin
                    state   <= RESP;
                    m_en    <= 1'b0;
                    m_we    <= 1'b0;
                    m_addr  <= '0;
                    m_wdata <= '0;
                    c_ack_q <= ~own_d;
                    d_ack_q <= own_d;
                end
                RESP: begin
                    state   <= IDLE;
                    c_ack_q <= 1'b0;
                    d_ack_q <= 1'b0;
                    rd_ok   <= 1'b0;
                    err_q   <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: memory model, timeline reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m_en;
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata = '0;
    logic [31:0] mem [32] = '{default: '0};

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    dmem_arbiter_if #(.DW(32)) c_if ();
    dmem_arbiter_if #(.DW(32)) d_if ();

    dmem_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .c       (c_if.slave),
        .d       (d_if.slave),
        .m_en    (m_en),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous single-port memory, one-cycle read latency.
    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) mem[m_addr] <= m_wdata;
            else      m_rdata     <= mem[m_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Reference model: a transaction accepted in cycle A shows up on
    // the memory in A+1 and answers in A+2; the arbiter is free at A+3.
    logic [31:0] ref_mem [32] = '{default: '0};
    bit          busy   = 1'b0;
    bit          last_d = 1'b1;
    int          acc    = 0;
    bit          t_d, t_we, t_oor;
    logic [31:0] t_addr, t_wdata, t_rd;
    logic        e_cg, e_dg, e_ca, e_da, e_ce, e_de, e_men, e_mwe;
    logic [31:0] e_cr, e_dr, e_ma, e_mw;

    always @(negedge clk) begin
        bit was;
        was   = busy;
        e_cg  = 0; e_dg = 0; e_ca = 0; e_da = 0;
        e_ce  = 0; e_de = 0; e_men = 0; e_mwe = 0;
        e_cr  = 0; e_dr = 0; e_ma = 0; e_mw = 0;
        if (rst) begin
            busy   = 0;
            last_d = 1;
        end else begin
            if (busy && cyc == acc + 1) begin
                e_men = !t_oor;
                e_mwe = t_we && !t_oor;
                e_ma  = 32'(t_addr[4:0]);
                e_mw  = t_wdata;
                if (!t_oor) begin
                    if (t_we) ref_mem[t_addr[4:0]] = t_wdata;
                    else      t_rd = ref_mem[t_addr[4:0]];
                end
            end
            if (busy && cyc == acc + 2) begin
                if (t_d) begin
                    e_da = 1; e_de = t_oor; e_dr = t_we ? 0 : t_rd;
                end else begin
                    e_ca = 1; e_ce = t_oor; e_cr = t_we ? 0 : t_rd;
                end
                busy = 0;
            end
            if (!was && (c_if.req || d_if.req)) begin
                t_d     = d_if.req && !(c_if.req && last_d);
                e_dg    = t_d;
                e_cg    = !t_d;
                t_we    = t_d ? d_if.we    : c_if.we;
                t_addr  = t_d ? d_if.addr  : c_if.addr;
                t_wdata = t_d ? d_if.wdata : c_if.wdata;
                t_oor   = t_addr >= 32;
                t_rd    = 0;
                busy    = 1;
                acc     = cyc;
                last_d  = t_d;
            end
        end
        chk("c_gnt", c_if.gnt, e_cg);
        chk("d_gnt", d_if.gnt, e_dg);
        chk("c_ack", c_if.ack, e_ca);
        chk("d_ack", d_if.ack, e_da);
        chk("c_err", c_if.err, e_ce);
        chk("d_err", d_if.err, e_de);
        chk("c_rdata", c_if.rdata, e_cr);
        chk("d_rdata", d_if.rdata, e_dr);
        chk("m_en", m_en, e_men);
        chk("m_we", m_we, e_mwe);
        if (e_men) begin
            chk("m_addr", 32'(m_addr), e_ma);
            chk("m_wdata", m_wdata, e_mw);
        end
    end

    task automatic drive(input bit port, input bit r, input bit we,
                         input logic [31:0] a, input logic [31:0] wd);
        if (port) begin
            d_if.req = r; d_if.we = we; d_if.addr = a; d_if.wdata = wd;
        end else begin
            c_if.req = r; c_if.we = we; c_if.addr = a; c_if.wdata = wd;
        end
    endtask

    // One transaction on one port with literal expectations:
    // gnt, then m_en one cycle later, then ack two cycles after gnt.
    task automatic xact(input bit port, input bit we,
                        input logic [31:0] a, input logic [31:0] wd,
                        input bit exp_men, input logic [31:0] exp_rd,
                        input bit exp_err);
        bit ok;
        ok = 0;
        @(posedge clk); #1;
        drive(port, 1, we, a, wd);
        for (int i = 0; i < 16 && !ok; i++) begin
            @(negedge clk);
            if (port ? d_if.gnt : c_if.gnt) ok = 1;
        end
        chk("x_gnt_seen", 32'(ok), 1);
        @(posedge clk); #1;
        drive(port, 0, 0, 0, 0);
        @(negedge clk);
        chk("x_m_en", 32'(m_en), 32'(exp_men));
        if (exp_men) chk("x_m_we", 32'(m_we), 32'(we));
        @(negedge clk);
        chk("x_ack", 32'(port ? d_if.ack : c_if.ack), 1);
        chk("x_other_ack", 32'(port ? c_if.ack : d_if.ack), 0);
        chk("x_err", 32'(port ? d_if.err : c_if.err), 32'(exp_err));
        if (!we) chk("x_rdata", port ? d_if.rdata : c_if.rdata, exp_rd);
    endtask

    int          g_cyc [8];
    bit          g_prt [8];
    int          g_n;
    logic [31:0] c_last, d_last;

    // Both ports hold loads until n grants have been observed.
    task automatic pair(input logic [31:0] ca, input logic [31:0] da,
                        input int n);
        g_n = 0;
        @(posedge clk); #1;
        drive(0, 1, 0, ca, 0);
        drive(1, 1, 0, da, 0);
        for (int i = 0; i < 40 && g_n < n; i++) begin
            @(negedge clk);
            chk("dual_gnt", 32'(c_if.gnt & d_if.gnt), 0);
            if (c_if.ack) c_last = c_if.rdata;
            if (d_if.ack) d_last = d_if.rdata;
            if (c_if.gnt || d_if.gnt) begin
                g_cyc[g_n] = cyc;
                g_prt[g_n] = d_if.gnt;
                g_n++;
            end
        end
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (c_if.ack) c_last = c_if.rdata;
            if (d_if.ack) d_last = d_if.rdata;
        end
        chk("pair_count", 32'(g_n), 32'(n));
        for (int i = 0; i < g_n; i++) begin
            chk("pair_order", 32'(g_prt[i]), 32'(i % 2));
            if (i > 0) chk("pair_gap", 32'(g_cyc[i] - g_cyc[i-1]), 3);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #3 rst = 1;
        @(posedge clk); @(posedge clk); #3 rst = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        #2 rst = 1;
        @(negedge clk);
        chk("rst_c_gnt", 32'(c_if.gnt), 0);
        chk("rst_m_en", 32'(m_en), 0);
        chk("rst_m_addr", 32'(m_addr), 0);
        chk("rst_c_rdata", c_if.rdata, 0);
        @(posedge clk); #3 rst = 0;

        xact(0, 1, 24, 32'hFFFFFFFF, 1, 0, 0);
        xact(0, 0, 24, 0, 1, 32'hFFFFFFFF, 0);

        xact(1, 1, 20, 32'hFFFFFFE3, 1, 0, 0);
        xact(0, 0, 20, 0, 1, 32'hFFFFFFE3, 0);

        xact(0, 1, 32, 32'h12345678, 0, 0, 1);
        xact(0, 0, 32'h80000000, 0, 0, 0, 1);
        for (int i = 0; i < 32; i++) begin
            logic [31:0] ev;
            ev = (i == 24) ? 32'hFFFFFFFF :
                 (i == 20) ? 32'hFFFFFFE3 : 32'h0;
            xact(1, 0, 32'(i), 0, 1, ev, 0);
        end

        do_reset();
        c_last = '1; d_last = '1;
        pair(24, 20, 4);
        chk("rr_c_rdata", c_last, 32'hFFFFFFFF);
        chk("rr_d_rdata", d_last, 32'hFFFFFFE3);

        // Reset lands in the ISSUE cycle of a store to addr 5.
        @(posedge clk); #1;
        drive(0, 1, 1, 5, 32'hA5A5A5A5);
        begin
            bit ok;
            ok = 0;
            for (int i = 0; i < 16 && !ok; i++) begin
                @(negedge clk);
                if (c_if.gnt) ok = 1;
            end
            chk("ri_gnt_seen", 32'(ok), 1);
        end
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0);
        #2 rst = 1;
        @(negedge clk);
        chk("ri_m_en", 32'(m_en), 0);
        chk("ri_c_ack", 32'(c_if.ack), 0);
        @(posedge clk); #3 rst = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ri_no_ack", 32'(c_if.ack), 0);
        end
        c_last = '1; d_last = '1;
        pair(5, 5, 2);
        chk("ri_c_rdata", c_last, 0);
        chk("ri_d_rdata", d_last, 0);

        // D request raised in ISSUE and withdrawn in RESP.
        @(posedge clk); #1;
        drive(0, 1, 0, 24, 0);
        begin
            bit ok;
            ok = 0;
            for (int i = 0; i < 16 && !ok; i++) begin
                @(negedge clk);
                if (c_if.gnt) ok = 1;
            end
            chk("wd_gnt_seen", 32'(ok), 1);
        end
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0);
        drive(1, 1, 1, 20, 32'hDEADBEEF);
        @(negedge clk);
        chk("wd_d_gnt_iss", 32'(d_if.gnt), 0);
        @(posedge clk); #1;
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        chk("wd_c_ack", 32'(c_if.ack), 1);
        chk("wd_c_rdata", c_if.rdata, 32'hFFFFFFFF);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("wd_d_gnt", 32'(d_if.gnt), 0);
            chk("wd_d_ack", 32'(d_if.ack), 0);
            chk("wd_m_en", 32'(m_en), 0);
        end
        chk("wd_mem20", ref_mem[20], 32'hFFFFFFE3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Round-robin arbiter and sequencer for the shared single-port data memory: 32 words of 32 bits, synchronous write, synchronous read with one-cycle latency. It sits between the data memory and its two requesters. Port C is the core's memory-access stage (ld/st); port D is the debug/loader port used to preload and dump data memory. It serialises accesses, drives the memory control signals, returns load data with an acknowledge, and flags out-of-range addresses instead of aliasing them.

## Interface
- DW, 32, data width
- DEPTH, 32, memory words
- AW, 5, memory address width (log2 DEPTH)
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- c_req  in  1  core request; held stable with c_we/c_addr/c_wdata until accepted
- c_we  in  1  1 = store, 0 = load
- c_addr  in  32  word address (byte address not used)
- c_wdata  in  DW  store data
- c_gnt  out  1  request accepted this cycle (req & gnt at posedge = accepted)
- c_ack  out  1  one-cycle completion pulse, for loads and stores
- c_rdata  out  DW  load data, valid only while c_ack and the transaction was a load
- c_err  out  1  asserted with c_ack when the address was out of range
- d_req, d_we, d_addr, d_wdata, d_gnt, d_ack, d_rdata, d_err: identical set for the debug port
- m_en  out  1  memory access enable
- m_we  out  1  memory write enable (only with m_en)
- m_addr  out  AW  memory word address
- m_wdata  out  DW  memory write data
- m_rdata  in  DW  memory read data, valid the cycle after m_en & !m_we

## Operation
- FSM states: IDLE, ISSUE, RESP. Reset state is IDLE.
- IDLE: if any req is high, pick a winner and assert its gnt combinationally in the same cycle. At the posedge, latch we/addr/wdata and the owner into txn registers, and go to ISSUE. With no req, stay in IDLE.
- Arbitration: with a single requester, that requester wins. With both, the winner is the port not granted last. The last_owner register resets to D, so C wins the first tie.
- ISSUE: if addr < DEPTH, drive m_en=1, m_we=txn_we, m_addr=addr[AW-1:0], m_wdata=txn_wdata. If the address is out of range, m_en=0 (store dropped, no memory access). Go to RESP.
- RESP: pulse owner's ack. For an in-range load, owner rdata = m_rdata. For an out-of-range load, rdata = 0. Owner err = out-of-range flag. Go to IDLE. No gnt is issued in ISSUE or RESP.
- Out of range: any of addr[31:AW] nonzero, or addr[AW-1:0] >= DEPTH.
- rdata of the non-owner port and during non-ack cycles is 0. Outputs are never driven Z.
- Requester-side rule: a req deasserted before gnt is simply not served, with no side effect.

## Timing
- Accept in cycle T (gnt=1) → m_en in T+1 → ack/rdata/err in T+2 → next gnt possible at T+3. Fixed 3-cycle occupancy per transaction, for loads and stores alike.
- Store data is written to memory at the posedge ending T+1. A load issued to the same address afterwards returns the new value.
- Both ports requesting continuously: grants alternate C, D, C, D…, one every 3 cycles. Neither port waits more than one foreign transaction.
- A request held through ISSUE/RESP is evaluated again in the next IDLE cycle.
- Reset values: all gnt/ack/err/rdata = 0; m_en = m_we = 0; m_addr = 0; m_wdata = 0; state = IDLE; last_owner = D.
- Reset mid-transaction (asynchronous): outputs drop to reset values immediately. An in-flight store whose m_en had not yet been sampled by the memory is lost, and no ack is produced. Requesters must re-issue after reset.
- Simultaneous req rising on both ports in the same cycle is resolved by last_owner only. It is never both granted.

## Test plan
- Single store then load on C: C stores 0xFFFFFFFF at addr 24 (gnt T, m_en/m_we T+1, c_ack T+2, c_err=0). Then C loads addr 24 → c_ack with c_rdata=0xFFFFFFFF exactly 2 cycles after its gnt.
- Round robin: after reset, both ports hold load requests continuously. Required grant order is C, D, C, D, with grants 3 cycles apart; d_gnt never occurs in the same cycle as c_gnt.
- Cross-port coherence: D stores 0xFFFFFFE3 at addr 20, then C loads addr 20 → c_rdata=0xFFFFFFE3; d_ack and c_ack each appear only on their own port.
- Out of range: C stores 0x12345678 at addr 32 → m_en stays 0, c_ack with c_err=1. A load from addr 0x80000000 → c_ack, c_err=1, c_rdata=0. Memory contents are unchanged, confirmed by a D-port dump of all 32 words.
- Reset in ISSUE: assert rst during the ISSUE cycle of a store to addr 5 → m_en drops immediately, no ack, state IDLE. After release, a C load is granted first (last_owner = D).
- Withdrawn request: D raises d_req while C's transaction is in ISSUE, then drops it before the next IDLE → no d_gnt, no d_ack, no memory access.
